// File: rtl/fetch_pkg.sv
// Shared constants and types for the femtoRV32 instruction fetch front end.
// Optional feature macro used by fetch_unit: FETCH_PERF_EN (stall counter).
package fetch_pkg;

  localparam int unsigned DEPTH_DEFAULT    = 4;
  localparam int unsigned DEPTH_LOG2       = $clog2(DEPTH_DEFAULT);
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, data} entries; pointers wrap modulo DEPTH (a power of two),
// full/empty come from the occupancy count, flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, credit-limited imem requests, discard of
// responses orphaned by a redirect. Define FETCH_PERF_EN to add the stall_cnt port.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          empty;
  logic          grant;
  logic          rsp;
  logic          keep;
  logic          pop;
  logic [31:0]   new_pc;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Buffered words plus outstanding requests never exceed DEPTH, so a response always has room.
  assign used      = {1'b0, count} + {1'b0, inflight};
  assign imem_req  = rst && (used < (CW + 1)'(DEPTH)) && !redirect;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  assign rsp          = imem_rvalid && (inflight != '0);
  assign keep         = rsp && (discard == '0) && !redirect;
  assign inflight_nxt = inflight + CW'(grant) - CW'(rsp);
  assign new_pc       = align_word(redirect_pc);

  // Decode handshake: a word transfers in any cycle with inst_valid && inst_ready; inst_valid
  // never depends on inst_ready, and data/pc stay stable while inst_valid is held.
  assign inst_valid = !empty && !redirect;
  assign pop        = inst_valid && inst_ready;
  assign inst_pc    = head.pc;
  assign inst_data  = head.data;

  assign push_entry.pc   = resp_pc;
  assign push_entry.data = imem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect) begin
        // Every request still outstanding after this cycle belongs to the old path.
        fetch_pc <= new_pc;
        resp_pc  <= new_pc;
        discard  <= inflight_nxt;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (keep) resp_pc <= resp_pc + 32'd4;
        if (rsp && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (keep),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (head),
    .count      (count),
    .empty      (empty)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (inst_ready && !inst_valid && !redirect && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table for sequential fetch, then
// hand-written redirect/backpressure sequences against an in-order memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model and scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        ready;
    logic        gnt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  pend_t       pq[$];
  logic [31:0] exp_q[$];
  vec_t        vecs[6];
  int          tests  = 0;
  int          fails  = 0;
  int          now    = 0;
  int          lat    = 1;
  int          grants = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_mem();
    if (pq.size() > 0 && pq[0].due <= now) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hdead_beef;
    end
  endtask

  // Record this cycle's handshakes, then advance to just after the next falling edge.
  task automatic step();
    logic [31:0] e;
    if (imem_rvalid) void'(pq.pop_front());
    if (imem_req && imem_gnt) begin
      pq.push_back('{imem_addr, now + lat});
      grants++;
    end
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got pc %h expected none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_data", inst_data, word_of(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
    now++;
    drive_mem();
    settle();
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    imem_gnt    = 1'b0;
    lat         = 1;
    pq.delete();
    exp_q.delete();
    drive_mem();
    settle();
    check("rst_req", imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_data", inst_data, 0);
`ifdef FETCH_PERF_EN
    check("rst_stall", stall_cnt, 0);
`endif
    step();
    step();
    rst    = 1'b1;
    grants = 0;
    settle();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      inst_ready = 1'b1;
      settle();
      step();
      n++;
    end
    inst_ready = 1'b0;
    settle();
    check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    // Sequential fetch, 1-cycle memory, decode always ready: cycle k requests 4(k-1),
    // inst_pc 4(k-3) from cycle 3.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0c, 1'b1, 32'h04};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0c};

    do_reset();
    exp_q = {32'h0, 32'h4, 32'h8, 32'hc};
    for (int i = 0; i < 6; i++) begin
      inst_ready = vecs[i].ready;
      imem_gnt   = vecs[i].gnt;
      settle();
      check("seq_req", imem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) check("seq_addr", imem_addr, vecs[i].exp_addr);
      check("seq_valid", inst_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check("seq_pc", inst_pc, vecs[i].exp_pc);
      step();
    end
`ifdef FETCH_PERF_EN
    check("seq_stall", stall_cnt, 2);
`endif
    inst_ready = 1'b0;
    check("seq_sb_empty", exp_q.size(), 0);

    // Backpressure: exactly DEPTH grants, then requests stop; ordered drain without gaps.
    do_reset();
    imem_gnt = 1'b1;
    repeat (10) step();
    check("bp_grants", grants, 4);
    check("bp_req_low", imem_req, 0);
    check("bp_valid", inst_valid, 1);
    check("bp_head_pc", inst_pc, 32'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
    for (int i = 0; i < 8; i++) begin
      inst_ready = 1'b1;
      settle();
      check("bp_no_gap", inst_valid, 1);
      step();
    end
    inst_ready = 1'b0;
    check("bp_sb_empty", exp_q.size(), 0);

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset();
    lat = 3;
    imem_gnt = 1'b1;
    inst_ready = 1'b1;
    step();
    step();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    settle();
    check("r2_req_low", imem_req, 0);
    step();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    settle();
    check("r2_req", imem_req, 1);
    check("r2_addr", imem_addr, 32'h100);
    exp_q = {32'h100, 32'h104};
    wait_drain(20);

    // Redirect coinciding with a response that would fill the FIFO.
    do_reset();
    imem_gnt = 1'b1;
    repeat (4) step();
    check("rf_rvalid_valid", inst_valid, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    settle();
    check("rf_valid_low", inst_valid, 0);
    check("rf_req_low", imem_req, 0);
    step();
    redirect = 1'b0;
    settle();
    check("rf_req", imem_req, 1);
    check("rf_addr", imem_addr, 32'h200);
    check("rf_flushed", inst_valid, 0);
    exp_q = {32'h200, 32'h204};
    wait_drain(20);

    // Misaligned redirect target, with the first response landing in the redirect cycle.
    do_reset();
    imem_gnt = 1'b1;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    settle();
    check("ma_req_low", imem_req, 0);
    step();
    redirect = 1'b0;
    settle();
    check("ma_req", imem_req, 1);
    check("ma_addr", imem_addr, 32'h100);
    exp_q = {32'h100, 32'h104, 32'h108};
    wait_drain(20);

    // Back-to-back redirects: the second one wins and recounts the discards.
    do_reset();
    lat = 3;
    imem_gnt = 1'b1;
    step();
    step();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    settle();
    step();
    redirect_pc = 32'h400;
    settle();
    check("bb_req_low", imem_req, 0);
    step();
    redirect = 1'b0;
    imem_gnt = 1'b1;
    settle();
    check("bb_addr", imem_addr, 32'h400);
    exp_q = {32'h400};
    wait_drain(20);

`ifdef FETCH_PERF_EN
    // Stall counter: grants withheld while decode is ready; async reset clears it.
    do_reset();
    inst_ready = 1'b1;
    repeat (5) step();
    check("perf_stall5", stall_cnt, 5);
    step();
    check("perf_stall6", stall_cnt, 6);
    rst = 1'b0;
    settle();
    check("perf_rst_clear", stall_cnt, 0);
    inst_ready = 1'b0;
    rst = 1'b1;
    settle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
